// File: rtl/mem_wait_responder.sv
// rtl/mem_wait_responder.sv - word memory responder with programmable wait states and req/ack handshake
module mem_wait_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH];

    logic          take;
    logic          enter_resp;
    logic          sel_we;
    logic          sel_err;
    logic          do_write;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [AW-1:0] sel_idx;

    // Select the request being completed: with a 1-cycle latency the request
    // completes on its acceptance edge, so the live inputs are used directly.
    always_comb begin
        take       = (state == IDLE) && req;
        enter_resp = (take && (LATENCY == 1)) || ((state == WAIT) && (cnt == 4'd1));
        if (state == IDLE) begin
            sel_we    = we;
            sel_addr  = addr;
            sel_wdata = wdata;
        end else begin
            sel_we    = we_q;
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
        end
        sel_idx  = sel_addr[AW+1:2];
        sel_err  = (sel_addr[1:0] != 2'b00) || (sel_addr >= LIMIT);
        do_write = enter_resp && sel_we && !sel_err;
    end

    // Storage array; never cleared, and no write lands while reset is held.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem[sel_idx] <= sel_wdata;
        end
    end

    // Handshake FSM with registered busy/ack/err/rdata.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            busy    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= 4'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                ack   <= 1'b1;
                err   <= sel_err;
                rdata <= (sel_we || sel_err) ? 32'd0 : mem[sel_idx];
            end
        end
    end

endmodule
